// File: rtl/cdb_arbiter.sv
// Arbitrates two common data buses among the ADD, MUL and load/store result producers.
// Each producer owns a small FIFO; up to two heads are granted per cycle, oldest ROB age first.
module cdb_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned PREG_W = 5,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [TAG_W-1:0]  ptr_old,
    input  logic              valid_add,
    input  logic              valid_mul,
    input  logic              valid_ls,
    input  logic [PREG_W-1:0] Pw_add,
    input  logic [PREG_W-1:0] Pw_mul,
    input  logic [PREG_W-1:0] Pw_ls,
    input  logic [TAG_W-1:0]  tag_add,
    input  logic [TAG_W-1:0]  tag_mul,
    input  logic [TAG_W-1:0]  tag_ls,
    input  logic [DATA_W-1:0] data_add,
    input  logic [DATA_W-1:0] data_mul,
    input  logic [DATA_W-1:0] data_ls,
    input  logic              mode_ls,
    output logic              ready_add,
    output logic              ready_mul,
    output logic              ready_ls,
    output logic              cdb0_valid,
    output logic              cdb1_valid,
    output logic [PREG_W-1:0] cdb0_Pw,
    output logic [PREG_W-1:0] cdb1_Pw,
    output logic [TAG_W-1:0]  cdb0_tag,
    output logic [TAG_W-1:0]  cdb1_tag,
    output logic [DATA_W-1:0] cdb0_data,
    output logic [DATA_W-1:0] cdb1_data,
    output logic              cdb0_mode,
    output logic              cdb1_mode,
    output logic [1:0]        cdb0_src,
    output logic [1:0]        cdb1_src,
    output logic              overflow_err
);

    localparam int unsigned NSRC  = 3;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PREG_W-1:0] pw;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              mode;
    } entry_t;

    entry_t             in_entry [NSRC];
    logic               in_valid [NSRC];
    entry_t             mem_q    [NSRC][DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [NSRC];
    logic [PTR_W-1:0]   rd_ptr_q [NSRC];
    logic [CNT_W-1:0]   count_q  [NSRC];

    logic               ready    [NSRC];
    logic               push     [NSRC];
    logic               cand     [NSRC];
    logic               grant    [NSRC];
    entry_t             head     [NSRC];
    logic [TAG_W-1:0]   age      [NSRC];
    logic [1:0]         older_cnt[NSRC];
    logic               drop;

    logic               sel0_valid, sel1_valid;
    logic [1:0]         sel0, sel1;

    entry_t             cdb0_q, cdb1_q;
    logic               cdb0_valid_q, cdb1_valid_q;
    logic [1:0]         cdb0_src_q, cdb1_src_q;
    logic               overflow_q;

    always_comb begin
        in_valid[0] = valid_add;
        in_valid[1] = valid_mul;
        in_valid[2] = valid_ls;
        in_entry[0] = '{pw: Pw_add, tag: tag_add, data: data_add, mode: 1'b0};
        in_entry[1] = '{pw: Pw_mul, tag: tag_mul, data: data_mul, mode: 1'b0};
        in_entry[2] = '{pw: Pw_ls,  tag: tag_ls,  data: data_ls,  mode: mode_ls};
    end

    always_comb begin
        drop = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            ready[i] = (count_q[i] != CNT_W'(DEPTH));
            push[i]  = in_valid[i] && ready[i];
            drop     = drop | (in_valid[i] && !ready[i]);
            cand[i]  = (count_q[i] != '0);
            head[i]  = mem_q[i][rd_ptr_q[i]];
            age[i]   = head[i].tag - ptr_old;
        end
    end

    // Rank each candidate by how many other candidates are older; ties go to the lower index.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            older_cnt[i] = 2'd0;
            for (int j = 0; j < NSRC; j++) begin
                if (j != i && cand[j] &&
                    ((age[j] < age[i]) || ((age[j] == age[i]) && (j < i)))) begin
                    older_cnt[i] = older_cnt[i] + 2'd1;
                end
            end
            grant[i] = cand[i] && (older_cnt[i] < 2'd2);
        end
    end

    always_comb begin
        sel0_valid = 1'b0;
        sel1_valid = 1'b0;
        sel0       = 2'd0;
        sel1       = 2'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i] && older_cnt[i] == 2'd0) begin
                sel0_valid = 1'b1;
                sel0       = 2'(i);
            end
            if (grant[i] && older_cnt[i] == 2'd1) begin
                sel1_valid = 1'b1;
                sel1       = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (push[i] && !flush) begin
                mem_q[i][wr_ptr_q[i]] <= in_entry[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSRC; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            cdb0_q       <= '0;
            cdb1_q       <= '0;
            cdb0_valid_q <= 1'b0;
            cdb1_valid_q <= 1'b0;
            cdb0_src_q   <= 2'd0;
            cdb1_src_q   <= 2'd0;
            overflow_q   <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (flush) begin
                for (int i = 0; i < NSRC; i++) begin
                    wr_ptr_q[i] <= '0;
                    rd_ptr_q[i] <= '0;
                    count_q[i]  <= '0;
                end
                cdb0_q       <= '0;
                cdb1_q       <= '0;
                cdb0_valid_q <= 1'b0;
                cdb1_valid_q <= 1'b0;
                cdb0_src_q   <= 2'd0;
                cdb1_src_q   <= 2'd0;
            end else begin
                for (int i = 0; i < NSRC; i++) begin
                    if (push[i]) begin
                        wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                    end
                    if (grant[i]) begin
                        rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                    end
                    if (push[i] && !grant[i]) begin
                        count_q[i] <= count_q[i] + CNT_W'(1);
                    end else if (!push[i] && grant[i]) begin
                        count_q[i] <= count_q[i] - CNT_W'(1);
                    end
                end
                cdb0_valid_q <= sel0_valid;
                cdb1_valid_q <= sel1_valid;
                cdb0_q       <= sel0_valid ? head[sel0] : '0;
                cdb1_q       <= sel1_valid ? head[sel1] : '0;
                cdb0_src_q   <= sel0_valid ? sel0 : 2'd0;
                cdb1_src_q   <= sel1_valid ? sel1 : 2'd0;
            end
        end
    end

    assign ready_add    = ready[0];
    assign ready_mul    = ready[1];
    assign ready_ls     = ready[2];
    assign cdb0_valid   = cdb0_valid_q;
    assign cdb1_valid   = cdb1_valid_q;
    assign cdb0_Pw      = cdb0_q.pw;
    assign cdb1_Pw      = cdb1_q.pw;
    assign cdb0_tag     = cdb0_q.tag;
    assign cdb1_tag     = cdb1_q.tag;
    assign cdb0_data    = cdb0_q.data;
    assign cdb1_data    = cdb1_q.data;
    assign cdb0_mode    = cdb0_q.mode;
    assign cdb1_mode    = cdb1_q.mode;
    assign cdb0_src     = cdb0_src_q;
    assign cdb1_src     = cdb1_src_q;
    assign overflow_err = overflow_q;

endmodule
